// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared register-file geometry and data types.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int RF_DW    = 16;
    localparam int RF_AW    = 3;
    localparam int RF_NREGS = 8;

    typedef logic [RF_AW-1:0] rf_num_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches req starting at
//                ptr and wrapping modulo NREQ; returns a one-hot grant and
//                the binary index of the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   winner
);

    logic          w_found;
    logic [PW:0]   w_idx;

    // First requester at or after ptr (modulo NREQ) wins.
    always_comb begin
        gnt     = '0;
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NREQ)) begin
                w_idx = w_idx - (PW+1)'(NREQ);
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                gnt[w_idx[PW-1:0]] = 1'b1;
                winner             = w_idx[PW-1:0];
                w_found            = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_port_arbiter
//  Description : Shares the register file's single read and single write
//                port between NREQ requesters with round-robin arbitration.
//                Grants are combinational; read data returns one cycle after
//                the grant, registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_num,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 rf_write,
    output logic [AW-1:0]        rf_writenum,
    output logic [DW-1:0]        rf_data_in,
    output logic [AW-1:0]        rf_readnum,
    input  logic [DW-1:0]        rf_data_out
);

    localparam int              c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(NREQ - 1);

    logic [c_PW-1:0]  r_ptr;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [DW-1:0]    r_rsp_data;

    logic [NREQ-1:0]  w_pick_gnt;
    logic [c_PW-1:0]  w_winner;
    logic             w_grant;
    logic             w_wr_grant;
    logic             w_rd_grant;
    logic [AW-1:0]    w_num;
    logic [DW-1:0]    w_wdata;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (c_PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .gnt    (w_pick_gnt),
        .winner (w_winner)
    );

    // Grants are suppressed while reset is held so nothing reaches the regfile.
    assign gnt        = w_pick_gnt & {NREQ{rst_n}};
    assign w_grant    = |gnt;
    assign w_wr_grant = w_grant &  req_we[w_winner];
    assign w_rd_grant = w_grant & ~req_we[w_winner];
    assign w_num      = req_num[int'(w_winner)*AW +: AW];
    assign w_wdata    = req_wdata[int'(w_winner)*DW +: DW];

    // Regfile port drive; everything is zero when no grant is active.
    always_comb begin
        rf_write    = w_wr_grant;
        rf_writenum = w_wr_grant ? w_num   : '0;
        rf_data_in  = w_wr_grant ? w_wdata : '0;
        rf_readnum  = w_rd_grant ? w_num   : '0;
    end

    // Round-robin pointer: advance past the winner, wrap after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
        end
    end

    // Read response register: capture regfile data and pulse the owner's valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else if (w_rd_grant) begin
            r_rsp_valid <= gnt;
            r_rsp_data  <= rf_data_out;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_port_arbiter
//  Description : Self-checking bench for regfile_port_arbiter with an attached
//                behavioural register file and a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_port_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NREG = 8;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_we;
    logic [NREQ*AW-1:0]  req_num;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                rf_write;
    logic [AW-1:0]       rf_writenum;
    logic [DW-1:0]       rf_data_in;
    logic [AW-1:0]       rf_readnum;
    logic [DW-1:0]       rf_data_out;

    regfile_port_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_we      (req_we),
        .req_num     (req_num),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rf_write    (rf_write),
        .rf_writenum (rf_writenum),
        .rf_data_in  (rf_data_in),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file attached to the arbiter; loaded with a known pattern in reset.
    logic [DW-1:0] rf_mem [NREG];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_mem[i] <= DW'(i * 16'h1111);
        end else if (rf_write) begin
            rf_mem[rf_writenum] <= rf_data_in;
        end
    end
    assign rf_data_out = rf_mem[rf_readnum];

    // Reference model state
    int            ref_ptr;
    logic [DW-1:0] ref_mem [NREG];
    logic [NREQ-1:0] exp_rsp_valid;
    logic [DW-1:0]   exp_rsp_data;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] num, input logic [DW-1:0] wd);
        req[i]               = v;
        req_we[i]            = we;
        req_num[i*AW +: AW]  = num;
        req_wdata[i*DW +: DW] = wd;
    endtask

    // Called just after a falling edge with inputs applied: checks this
    // cycle's outputs against the model, then advances the model at the edge.
    task automatic run_cycle();
        int              win;
        int              idx;
        logic [NREQ-1:0] eg;
        logic            we;
        logic [AW-1:0]   num;
        logic [DW-1:0]   wd;
        #2;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ref_ptr + k) % NREQ;
            if (win < 0 && req[idx]) win = idx;
        end
        eg  = '0;
        we  = 1'b0;
        num = '0;
        wd  = '0;
        if (win >= 0) begin
            eg[win] = 1'b1;
            we      = req_we[win];
            num     = req_num[win*AW +: AW];
            wd      = req_wdata[win*DW +: DW];
        end
        check("gnt",         32'(gnt),         32'(eg));
        check("rf_write",    32'(rf_write),    32'(win >= 0 && we));
        check("rf_writenum", 32'(rf_writenum), (win >= 0 && we)  ? 32'(num) : 32'd0);
        check("rf_data_in",  32'(rf_data_in),  (win >= 0 && we)  ? 32'(wd)  : 32'd0);
        check("rf_readnum",  32'(rf_readnum),  (win >= 0 && !we) ? 32'(num) : 32'd0);
        check("rsp_valid",   32'(rsp_valid),   32'(exp_rsp_valid));
        check("rsp_data",    32'(rsp_data),    32'(exp_rsp_data));
        @(posedge clk);
        exp_rsp_valid = '0;
        if (win >= 0) begin
            ref_ptr = (win + 1) % NREQ;
            if (we) begin
                ref_mem[num] = wd;
            end else begin
                exp_rsp_valid = eg;
                exp_rsp_data  = ref_mem[num];
            end
        end
        @(negedge clk);
    endtask

    // Reset held across one rising edge; outputs must stay quiet throughout.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt",       32'(gnt),       32'd0);
        check("rst_rf_write",  32'(rf_write),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        ref_ptr       = 0;
        exp_rsp_valid = '0;
        exp_rsp_data  = '0;
        for (int i = 0; i < NREG; i++) ref_mem[i] = DW'(i * 16'h1111);
        @(posedge clk);
        #1;
        check("rst_rsp_valid_edge", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = '0;
        req_we    = '0;
        req_num   = '0;
        req_wdata = '0;
        @(negedge clk);

        // Reset with both requesting, then first grant goes to requester 0
        set_req(0, 1'b1, 1'b0, 3'd1, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd2, 16'h0);
        do_reset();
        run_cycle();
        req = '0;
        run_cycle();

        // Write then read of the same register on consecutive cycles
        do_reset();
        set_req(0, 1'b1, 1'b1, 3'd3, 16'hBEEF);
        run_cycle();
        req = '0;
        set_req(1, 1'b1, 1'b0, 3'd3, 16'h0);
        run_cycle();
        req = '0;
        run_cycle();

        // Sustained contention alternates 01,10,01,10
        set_req(0, 1'b1, 1'b0, 3'd4, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd5, 16'h0);
        repeat (4) run_cycle();
        req = '0;
        run_cycle();

        // Simultaneous write and read of R7
        set_req(0, 1'b1, 1'b1, 3'd7, 16'h1234);
        set_req(1, 1'b1, 1'b0, 3'd7, 16'h0);
        run_cycle();
        req[0] = 1'b0;
        run_cycle();
        req = '0;
        run_cycle();

        // Aborted write from requester 1 must not reach the regfile
        set_req(0, 1'b1, 1'b1, 3'd2, 16'h5A5A);
        set_req(1, 1'b1, 1'b1, 3'd5, 16'hABCD);
        run_cycle();
        req = '0;
        run_cycle();
        set_req(1, 1'b1, 1'b0, 3'd5, 16'h0);
        run_cycle();
        req = '0;
        run_cycle();

        // Reset arriving while a read response is pending
        set_req(0, 1'b1, 1'b0, 3'd3, 16'h0);
        run_cycle();
        req = '0;
        #1;
        check("pending_rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
        do_reset();
        set_req(0, 1'b1, 1'b0, 3'd6, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd1, 16'h0);
        run_cycle();
        req = '0;
        run_cycle();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            if (($urandom % 150) == 0) begin
                req = '0;
                do_reset();
            end
            req       = NREQ'($urandom);
            req_we    = NREQ'($urandom);
            req_num   = (NREQ*AW)'($urandom);
            req_wdata = (NREQ*DW)'($urandom);
            run_cycle();
        end
        req = '0;
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
